// File: rtl/led_uart_tx_pkg.sv
// rtl/led_uart_tx_pkg.sv - shared TX state encodings and baud default
package led_uart_tx_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // 50 MHz system clock at 115200 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/led_uart_tx_sync_fifo.sv
// rtl/led_uart_tx_sync_fifo.sv - synchronous FIFO with combinational head output
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iPush,
  input  logic             iPop,
  input  logic [WIDTH-1:0] iData,
  output logic [WIDTH-1:0] oData,
  output logic             oFull,
  output logic             oEmpty,
  output logic [AW:0]      oCount
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign oFull  = (count_q == (AW+1)'(DEPTH));
  assign oEmpty = (count_q == '0);
  assign oCount = count_q;
  assign oData  = mem_q[rd_ptr_q];

  // A push while full is still taken when a pop frees the head slot this cycle.
  assign do_pop  = iPop && !oEmpty;
  assign do_push = iPush && (!oFull || do_pop);

  always_ff @(posedge Clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= iData;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/led_uart_tx.sv
// rtl/led_uart_tx.sv - captures LED bytes into a FIFO and sends them as 8N1 UART frames
module led_uart_tx
  import led_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 8,
  parameter int ADDR_W       = 3
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [7:0]        iData,
  input  logic              iValid,
  output logic              oTx,
  output logic              oBusy,
  output logic              oFull,
  output logic              oOverflow,
  output logic [ADDR_W:0]   oCount
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  tx_state_e         state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_q;
  logic [7:0]        shift_q;
  logic              tx_q;
  logic              overflow_q;

  logic [7:0]        fifo_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ADDR_W:0]   fifo_count;
  logic              pop;
  logic              overflow_d;
  logic              baud_tc;

  assign pop        = (state_q == TX_IDLE) && !fifo_empty;
  assign overflow_d = overflow_q || (iValid && fifo_full && !pop);
  assign baud_tc    = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clock  (Clock),
    .Reset  (Reset),
    .iPush  (iValid),
    .iPop   (pop),
    .iData  (iData),
    .oData  (fifo_data),
    .oFull  (fifo_full),
    .oEmpty (fifo_empty),
    .oCount (fifo_count)
  );

  // The line level is registered from the current state, so it trails the FSM by one cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= TX_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      case (state_q)
        TX_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= fifo_data;
            baud_q  <= '0;
            state_q <= TX_START;
          end
        end
        TX_START: begin
          tx_q <= 1'b0;
          if (baud_tc) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= TX_DATA;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        TX_DATA: begin
          tx_q <= shift_q[0];
          if (baud_tc) begin
            baud_q  <= '0;
            shift_q <= {1'b0, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_q <= TX_STOP;
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        TX_STOP: begin
          tx_q <= 1'b1;
          if (baud_tc) begin
            baud_q  <= '0;
            state_q <= TX_IDLE;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= TX_IDLE;
        end
      endcase
    end
  end

  assign oTx       = tx_q;
  assign oBusy     = (state_q != TX_IDLE) || !fifo_empty;
  assign oFull     = fifo_full;
  assign oOverflow = overflow_q;
  assign oCount    = fifo_count;

endmodule

// File: tb/tb_led_uart_tx.sv
// tb/tb_led_uart_tx.sv - randomized self-checking bench with frame-level reference model
module tb_led_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          Clock;
  logic          Reset;
  logic [7:0]    iData;
  logic          iValid;
  logic          oTx;
  logic          oBusy;
  logic          oFull;
  logic          oOverflow;
  logic [AW:0]   oCount;

  led_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .ADDR_W       (AW)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .iData     (iData),
    .iValid    (iValid),
    .oTx       (oTx),
    .oBusy     (oBusy),
    .oFull     (oFull),
    .oOverflow (oOverflow),
    .oCount    (oCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_vec;
  int n_err;

  // Reference model: byte queue plus the edge at which the current frame started.
  logic [7:0] q_m[$];
  int         edge_n;
  int         next_pop_ok;
  int         frame_start;
  logic [7:0] frame_byte;
  bit         ovf_m;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  function automatic logic exp_tx();
    int k;
    if (edge_n >= frame_start && edge_n < frame_start + 10 * CPB) begin
      k = (edge_n - frame_start) / CPB;
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return frame_byte[k-1];
    end
    return 1'b1;
  endfunction

  task automatic check_all(input string tag);
    logic busy_m;
    busy_m = (edge_n < next_pop_ok - 1) || (q_m.size() != 0);
    check_val({tag, "_tx"},    32'(oTx),       32'(exp_tx()));
    check_val({tag, "_count"}, 32'(oCount),    32'(q_m.size()));
    check_val({tag, "_full"},  32'(oFull),     32'(q_m.size() == DEPTH));
    check_val({tag, "_ovf"},   32'(oOverflow), 32'(ovf_m));
    check_val({tag, "_busy"},  32'(oBusy),     32'(busy_m));
  endtask

  task automatic step(input string tag, input logic v, input logic [7:0] d);
    iValid = v;
    iData  = d;
    @(posedge Clock);
    #1;
    edge_n++;
    if (edge_n >= next_pop_ok && q_m.size() != 0) begin
      frame_byte  = q_m.pop_front();
      frame_start = edge_n + 1;
      next_pop_ok = edge_n + 10 * CPB + 1;
    end
    if (v) begin
      if (q_m.size() < DEPTH) q_m.push_back(d);
      else ovf_m = 1'b1;
    end
    iValid = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    Reset  = 1'b1;
    iValid = 1'b0;
    @(posedge Clock);
    #1;
    edge_n++;
    q_m.delete();
    next_pop_ok = 0;
    frame_start = -1000;
    ovf_m       = 1'b0;
    Reset       = 1'b0;
    check_val({tag, "_tx"},    32'(oTx),       32'd1);
    check_val({tag, "_count"}, 32'(oCount),    32'd0);
    check_val({tag, "_busy"},  32'(oBusy),     32'd0);
    check_val({tag, "_full"},  32'(oFull),     32'd0);
    check_val({tag, "_ovf"},   32'(oOverflow), 32'd0);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 8'h00);
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    edge_n      = 0;
    next_pop_ok = 0;
    frame_start = -1000;
    frame_byte  = 8'h00;
    ovf_m       = 1'b0;
    Reset       = 1'b1;
    iValid      = 1'b0;
    iData       = 8'h00;
    repeat (2) @(posedge Clock);

    // Single byte A5
    do_reset("t1_rst");
    step("t1_push", 1'b1, 8'hA5);
    idle("t1", 50);

    // Three back-to-back strobes
    do_reset("t2_rst");
    for (int i = 1; i <= 3; i++) step("t2_push", 1'b1, 8'(i));
    idle("t2", 130);

    // Six strobes while idle: the last one overflows
    do_reset("t3_rst");
    for (int i = 0; i < 6; i++) step("t3_push", 1'b1, 8'h10 + 8'(i));
    check_val("t3_ovf_set", 32'(oOverflow), 32'd1);
    idle("t3", 5 * 10 * CPB + 10);
    check_val("t3_ovf_sticky", 32'(oOverflow), 32'd1);

    // Strobe on the pop edge while full is accepted
    do_reset("t4_rst");
    for (int i = 0; i < 5; i++) step("t4_push", 1'b1, 8'h20 + 8'(i));
    for (int i = 0; i < 100 && edge_n + 1 != next_pop_ok; i++) step("t4_wait", 1'b0, 8'h00);
    check_val("t4_at_pop_edge", 32'(edge_n + 1 == next_pop_ok), 32'd1);
    step("t4_pop_push", 1'b1, 8'h99);
    check_val("t4_count_kept", 32'(oCount), 32'd4);
    check_val("t4_no_ovf", 32'(oOverflow), 32'd0);
    idle("t4", 5 * 10 * CPB + 10);

    // Reset during DATA bit 3 of FF with two bytes queued
    do_reset("t5_rst");
    step("t5_push", 1'b1, 8'hFF);
    step("t5_push", 1'b1, 8'h3C);
    step("t5_push", 1'b1, 8'hC3);
    idle("t5", 15);
    do_reset("t5_midframe");
    idle("t5_after", 100);

    // Quiet line after reset
    do_reset("t6_rst");
    idle("t6", 100);

    // Random traffic
    do_reset("rnd_rst");
    for (int i = 0; i < 600; i++) begin
      step("rnd", ($urandom_range(0, 5) == 0), 8'($urandom));
    end
    idle("rnd_drain", 5 * 10 * CPB + 10);
    check_val("rnd_drained_busy", 32'(oBusy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
